rx_iq_fifo_ctrl: RTL and testbench

Buffers DDC receive I/Q pairs between the DDC output and stm32_interface.
- Schedules readout to the STM32: raises a ready/IRQ line once a watermark of samples is queued.
- Pops one pair per RX IQ transaction.
- Tracks overflow and underrun so firmware can detect lost samples.
- Sits in the FPGA top level, between the DDC decimator output and the RX IQ source inputs of stm32_interface.

---
 rtl/rx_iq_fifo_ctrl.sv | 110 +++++++++++
 tb/tb_rx_iq_fifo_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_iq_fifo_ctrl.sv
// RX I/Q sample FIFO between the DDC output and the STM32 bus interface.
// Watermark IRQ with hysteresis, saturating overflow count, sticky underrun.
module rx_iq_fifo_ctrl #(
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int THRESHOLD = 8
) (
   input  logic               clk_in,
   input  logic               reset,
   input  logic               iq_valid,
   input  logic signed [15:0] I_in,
   input  logic signed [15:0] Q_in,
   input  logic               pop,
   input  logic               flush,
   output logic signed [15:0] I_out,
   output logic signed [15:0] Q_out,
   output logic               out_valid,
   output logic [AW:0]        level,
   output logic               irq_ready,
   output logic [7:0]         overflow_cnt,
   output logic               underrun
);

   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] C_THR  = (AW+1)'(THRESHOLD);

   logic [31:0]        r_mem [DEPTH];
   logic [AW-1:0]      r_wptr;
   logic [AW-1:0]      r_rptr;
   logic [AW:0]        r_level;
   logic signed [15:0] r_i_out;
   logic signed [15:0] r_q_out;
   logic               r_out_valid;
   logic               r_irq;
   logic [7:0]         r_ovf;
   logic               r_underrun;

   logic               w_pop_ok;
   logic               w_push_ok;
   logic [AW:0]        w_level_nxt;

   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign w_pop_ok  = pop & (r_level != '0);
   assign w_push_ok = iq_valid & ((r_level != C_FULL) | w_pop_ok);

   always_comb begin
      w_level_nxt = r_level;
      if (w_push_ok && !w_pop_ok)
         w_level_nxt = r_level + 1'b1;
      else if (!w_push_ok && w_pop_ok)
         w_level_nxt = r_level - 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (!reset && !flush && w_push_ok)
         r_mem[r_wptr] <= {I_in, Q_in};
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_level     <= '0;
         r_i_out     <= '0;
         r_q_out     <= '0;
         r_out_valid <= 1'b0;
         r_irq       <= 1'b0;
         r_ovf       <= '0;
         r_underrun  <= 1'b0;
      end else if (flush) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_level     <= '0;
         r_out_valid <= 1'b0;
         r_irq       <= 1'b0;
         r_ovf       <= '0;
         r_underrun  <= 1'b0;
      end else begin
         r_level     <= w_level_nxt;
         r_out_valid <= pop;
         if (w_push_ok)
            r_wptr <= r_wptr + 1'b1;
         if (iq_valid && !w_push_ok && r_ovf != 8'hFF)
            r_ovf <= r_ovf + 1'b1;
         if (w_pop_ok) begin
            r_i_out <= r_mem[r_rptr][31:16];
            r_q_out <= r_mem[r_rptr][15:0];
            r_rptr  <= r_rptr + 1'b1;
         end else if (pop) begin
            r_i_out    <= '0;
            r_q_out    <= '0;
            r_underrun <= 1'b1;
         end
         // Hysteresis: set at the watermark, drop only once drained.
         if (w_level_nxt >= C_THR)
            r_irq <= 1'b1;
         else if (w_level_nxt == '0)
            r_irq <= 1'b0;
      end
   end

   assign I_out        = r_i_out;
   assign Q_out        = r_q_out;
   assign out_valid    = r_out_valid;
   assign level        = r_level;
   assign irq_ready    = r_irq;
   assign overflow_cnt = r_ovf;
   assign underrun     = r_underrun;

endmodule

// File: tb/tb_rx_iq_fifo_ctrl.sv
// Scoreboard bench for rx_iq_fifo_ctrl: expected pops queued at issue,
// a negedge monitor compares every out_valid pulse.
module tb_rx_iq_fifo_ctrl;

   logic        clk_in = 1'b0;
   logic        reset = 1'b0;
   logic        iq_valid = 1'b0;
   logic [15:0] I_in = '0;
   logic [15:0] Q_in = '0;
   logic        pop = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] I_out;
   logic [15:0] Q_out;
   logic        out_valid;
   logic [4:0]  level;
   logic        irq_ready;
   logic [7:0]  overflow_cnt;
   logic        underrun;

   int checks = 0;
   int errors = 0;

   logic [31:0] exq[$];
   logic [31:0] mq[$];
   int          mov = 0;
   bit          mun = 0;
   bit          mirq = 0;
   logic [31:0] mlast = '0;

   rx_iq_fifo_ctrl #(.DEPTH(16), .AW(4), .THRESHOLD(8)) dut (
      .clk_in(clk_in), .reset(reset), .iq_valid(iq_valid),
      .I_in(I_in), .Q_in(Q_in), .pop(pop), .flush(flush),
      .I_out(I_out), .Q_out(Q_out), .out_valid(out_valid),
      .level(level), .irq_ready(irq_ready),
      .overflow_cnt(overflow_cnt), .underrun(underrun)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk_in) begin
      if (out_valid === 1'b1) begin
         if (exq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h%h expected none",
                     I_out, Q_out);
         end else begin
            chk("pop_data", {I_out, Q_out}, exq.pop_front());
         end
      end
   end

   task automatic status();
      chk("level", 32'(level), 32'(mq.size()));
      chk("irq_ready", 32'(irq_ready), 32'(mirq));
      chk("overflow_cnt", 32'(overflow_cnt), 32'(mov));
      chk("underrun", 32'(underrun), 32'(mun));
   endtask

   task automatic cyc(input bit pu, input logic [15:0] di,
                      input logic [15:0] dq, input bit po, input bit fl);
      int n;
      bit pok;
      logic [31:0] e;
      if (fl) begin
         mq.delete();
         mov = 0;
         mun = 0;
         mirq = 0;
      end else begin
         n = mq.size();
         pok = po && n > 0;
         if (po) begin
            if (pok) e = mq.pop_front();
            else begin
               e = '0;
               mun = 1;
            end
            exq.push_back(e);
            mlast = e;
         end
         if (pu) begin
            if (n < 16 || pok) mq.push_back({di, dq});
            else if (mov != 255) mov++;
         end
         if (mq.size() >= 8) mirq = 1;
         else if (mq.size() == 0) mirq = 0;
      end
      iq_valid = pu;
      I_in = di;
      Q_in = dq;
      pop = po;
      flush = fl;
      @(posedge clk_in);
      #1;
      iq_valid = 0;
      pop = 0;
      flush = 0;
      status();
   endtask

   task automatic push(input logic [15:0] di, input logic [15:0] dq);
      cyc(1, di, dq, 0, 0);
   endtask

   task automatic popc();
      cyc(0, '0, '0, 1, 0);
   endtask

   task automatic rst(input bit po);
      reset = 1;
      pop = po;
      iq_valid = po;
      @(posedge clk_in);
      #1;
      reset = 0;
      pop = 0;
      iq_valid = 0;
      mq.delete();
      mov = 0;
      mun = 0;
      mirq = 0;
      mlast = '0;
      chk("rst_I_out", 32'(I_out), 0);
      chk("rst_Q_out", 32'(Q_out), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      status();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk_in);
      #1;
      rst(0);

      push(16'h1111, 16'h2222);
      push(16'h3333, 16'h4444);
      push(16'h7FFF, 16'h8000);
      chk("level_3", 32'(level), 3);
      for (int i = 0; i < 3; i++) begin
         popc();
         chk("level_dec", 32'(level), 32'(2 - i));
         cyc(0, '0, '0, 0, 0);
         chk("pulse_one_cycle", 32'(out_valid), 0);
      end
      chk("underrun_clear", 32'(underrun), 0);

      for (int i = 0; i < 8; i++) begin
         push(16'h0100 + 16'(i), 16'h0200 + 16'(i));
         chk("irq_rise", 32'(irq_ready), (i == 7) ? 1 : 0);
      end
      for (int i = 0; i < 7; i++) popc();
      chk("irq_hold", 32'(irq_ready), 1);
      chk("level_1", 32'(level), 1);
      popc();
      chk("irq_fall", 32'(irq_ready), 0);

      for (int i = 0; i < 20; i++) push(16'h1000 + 16'(i), 16'hA000 + 16'(i));
      chk("full_level", 32'(level), 16);
      chk("ovf_4", 32'(overflow_cnt), 4);
      for (int i = 0; i < 16; i++) popc();
      for (int i = 0; i < 16; i++) push(16'h2000 + 16'(i), 16'h5000 + 16'(i));
      cyc(1, 16'hBEEF, 16'hCAFE, 1, 0);
      chk("full_pp_level", 32'(level), 16);
      chk("full_pp_ovf", 32'(overflow_cnt), 4);
      for (int i = 0; i < 300; i++) push(16'hDEAD, 16'h0000);
      chk("ovf_sat", 32'(overflow_cnt), 255);
      for (int i = 0; i < 16; i++) popc();
      chk("drained", 32'(level), 0);

      for (int i = 0; i < 40; i++)
         cyc((i % 4) != 3, 16'h3000 + 16'(i), 16'h6000 - 16'(i),
             (i % 3) == 0, 0);
      while (level != 0) popc();

      popc();
      chk("underrun_set", 32'(underrun), 1);
      push(16'h0A0A, 16'h0B0B);
      popc();
      chk("underrun_sticky", 32'(underrun), 1);
      cyc(1, 16'h0C0C, 16'h0D0D, 1, 0);
      chk("pp_empty_level", 32'(level), 1);

      for (int i = 0; i < 9; i++) push(16'h4000 + 16'(i), 16'h4100 + 16'(i));
      popc();
      chk("pre_flush_irq", 32'(irq_ready), 1);
      cyc(1, 16'h7777, 16'h7777, 1, 1);
      chk("flush_level", 32'(level), 0);
      chk("flush_irq", 32'(irq_ready), 0);
      chk("flush_ovf", 32'(overflow_cnt), 0);
      chk("flush_underrun", 32'(underrun), 0);
      chk("flush_out_valid", 32'(out_valid), 0);
      chk("flush_hold_out", {I_out, Q_out}, mlast);

      push(16'h5555, 16'h6666);
      push(16'h1234, 16'h5678);
      popc();
      rst(1);

      repeat (3) @(posedge clk_in);
      #1;
      chk("scoreboard_empty", 32'(exq.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
